// File: rtl/dsp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_pkg : shared types, defaults and saturation helper for the S-DSP path
// Rev 1.0
// ---------------------------------------------------------------------------
package dsp_pkg;

   localparam int N_VOICES_DEF  = 8;
   localparam int SAMPLE_W_DEF  = 16;
   localparam int VOL_W_DEF     = 8;
   localparam int VOL_SHIFT_DEF = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      MASTER = 2'd2,
      DONE   = 2'd3
   } mix_state_t;

   // Clamp a wide signed value into the range of a w-bit signed number.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                    input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_sat_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_sat_mac : combinational acc + ((sample * vol) >>> VOL_SHIFT), saturated
// Rev 1.0
// ---------------------------------------------------------------------------
module dsp_sat_mac
   import dsp_pkg::*;
#(
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int VOL_W     = VOL_W_DEF,
   parameter int VOL_SHIFT = VOL_SHIFT_DEF
) (
   input  logic signed [SAMPLE_W-1:0] acc,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic signed [VOL_W-1:0]    vol,
   input  logic                       en,
   output logic signed [SAMPLE_W-1:0] result
);

   logic signed [63:0] prod;
   logic signed [63:0] term;
   logic signed [63:0] sum;
   logic signed [63:0] sat;

   // Working at 64 bits keeps the sum exact, so one clamp covers every overflow.
   always_comb begin
      prod   = 64'(sample) * 64'(vol);
      term   = prod >>> VOL_SHIFT;
      sum    = 64'(acc) + term;
      sat    = sat_clamp(sum, SAMPLE_W);
      result = en ? SAMPLE_W'(sat) : acc;
   end

endmodule
`default_nettype wire

// File: rtl/dsp_voice_mixer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_voice_mixer : one-voice-per-clock saturating mixer with echo send
// Rev 1.0
// ---------------------------------------------------------------------------
module dsp_voice_mixer
   import dsp_pkg::*;
#(
   parameter int N_VOICES  = N_VOICES_DEF,
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int VOL_W     = VOL_W_DEF,
   parameter int VOL_SHIFT = VOL_SHIFT_DEF
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [N_VOICES*SAMPLE_W-1:0] voice_sample,
   input  logic [N_VOICES*VOL_W-1:0]    voice_vol_l,
   input  logic [N_VOICES*VOL_W-1:0]    voice_vol_r,
   input  logic signed [VOL_W-1:0]      mvol_l,
   input  logic signed [VOL_W-1:0]      mvol_r,
   input  logic [N_VOICES-1:0]          eon,
   input  logic                         mute,
   output logic                         busy,
   output logic                         out_valid,
   output logic signed [SAMPLE_W-1:0]   out_l,
   output logic signed [SAMPLE_W-1:0]   out_r,
   output logic signed [SAMPLE_W-1:0]   echo_l,
   output logic signed [SAMPLE_W-1:0]   echo_r
);

   localparam int                IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_VOICES - 1);

   logic signed [SAMPLE_W-1:0] smp   [N_VOICES];
   logic signed [VOL_W-1:0]    vol_l [N_VOICES];
   logic signed [VOL_W-1:0]    vol_r [N_VOICES];

   for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_unpack
      assign smp[gi]   = voice_sample[gi*SAMPLE_W +: SAMPLE_W];
      assign vol_l[gi] = voice_vol_l[gi*VOL_W +: VOL_W];
      assign vol_r[gi] = voice_vol_r[gi*VOL_W +: VOL_W];
   end

   mix_state_t                 state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic signed [SAMPLE_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic signed [SAMPLE_W-1:0] ech_l_q, ech_l_d, ech_r_q, ech_r_d;
   logic signed [SAMPLE_W-1:0] mst_l_q, mst_l_d, mst_r_q, mst_r_d;
   logic signed [SAMPLE_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
   logic signed [SAMPLE_W-1:0] echo_l_q, echo_l_d, echo_r_q, echo_r_d;
   logic                       busy_q, busy_d, out_valid_q, out_valid_d;

   logic signed [SAMPLE_W-1:0] cur_smp;
   logic signed [SAMPLE_W-1:0] cur_vol_l_ext, cur_vol_r_ext;
   logic signed [VOL_W-1:0]    cur_vol_l, cur_vol_r;
   logic                       cur_eon;
   logic signed [SAMPLE_W-1:0] sum_l, sum_r, sum_el, sum_er, mst_l_w, mst_r_w;

   assign cur_smp   = smp[idx_q];
   assign cur_vol_l = vol_l[idx_q];
   assign cur_vol_r = vol_r[idx_q];
   assign cur_eon   = eon[idx_q];

   dsp_sat_mac #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .VOL_SHIFT(VOL_SHIFT)) u_mac_l (
      .acc(acc_l_q), .sample(cur_smp), .vol(cur_vol_l), .en(1'b1), .result(sum_l));
   dsp_sat_mac #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .VOL_SHIFT(VOL_SHIFT)) u_mac_r (
      .acc(acc_r_q), .sample(cur_smp), .vol(cur_vol_r), .en(1'b1), .result(sum_r));
   dsp_sat_mac #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .VOL_SHIFT(VOL_SHIFT)) u_mac_el (
      .acc(ech_l_q), .sample(cur_smp), .vol(cur_vol_l), .en(cur_eon), .result(sum_el));
   dsp_sat_mac #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .VOL_SHIFT(VOL_SHIFT)) u_mac_er (
      .acc(ech_r_q), .sample(cur_smp), .vol(cur_vol_r), .en(cur_eon), .result(sum_er));

   // Master stage reuses the MAC with a zero accumulator: a plain multiply-clamp.
   dsp_sat_mac #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .VOL_SHIFT(VOL_SHIFT)) u_mac_ml (
      .acc('0), .sample(acc_l_q), .vol(mvol_l), .en(1'b1), .result(mst_l_w));
   dsp_sat_mac #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .VOL_SHIFT(VOL_SHIFT)) u_mac_mr (
      .acc('0), .sample(acc_r_q), .vol(mvol_r), .en(1'b1), .result(mst_r_w));

   // Kept only to make the sign-extension intent visible in waveforms.
   assign cur_vol_l_ext = SAMPLE_W'(cur_vol_l);
   assign cur_vol_r_ext = SAMPLE_W'(cur_vol_r);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_l_d     = acc_l_q;
      acc_r_d     = acc_r_q;
      ech_l_d     = ech_l_q;
      ech_r_d     = ech_r_q;
      mst_l_d     = mst_l_q;
      mst_r_d     = mst_r_q;
      out_l_d     = out_l_q;
      out_r_d     = out_r_q;
      echo_l_d    = echo_l_q;
      echo_r_d    = echo_r_q;
      busy_d      = busy_q;
      out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = ACCUM;
               idx_d   = '0;
               acc_l_d = '0;
               acc_r_d = '0;
               ech_l_d = '0;
               ech_r_d = '0;
               busy_d  = 1'b1;
            end
         end
         ACCUM: begin
            acc_l_d = sum_l;
            acc_r_d = sum_r;
            ech_l_d = sum_el;
            ech_r_d = sum_er;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = MASTER;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         MASTER: begin
            mst_l_d = mute ? '0 : mst_l_w;
            mst_r_d = mute ? '0 : mst_r_w;
            state_d = DONE;
         end
         DONE: begin
            out_l_d     = mst_l_q;
            out_r_d     = mst_r_q;
            echo_l_d    = ech_l_q;
            echo_r_d    = ech_r_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_l_q     <= '0;
         acc_r_q     <= '0;
         ech_l_q     <= '0;
         ech_r_q     <= '0;
         mst_l_q     <= '0;
         mst_r_q     <= '0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         echo_l_q    <= '0;
         echo_r_q    <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_l_q     <= acc_l_d;
         acc_r_q     <= acc_r_d;
         ech_l_q     <= ech_l_d;
         ech_r_q     <= ech_r_d;
         mst_l_q     <= mst_l_d;
         mst_r_q     <= mst_r_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         echo_l_q    <= echo_l_d;
         echo_r_q    <= echo_r_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_l     = out_l_q;
   assign out_r     = out_r_q;
   assign echo_l    = echo_l_q;
   assign echo_r    = echo_r_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_voice_mixer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dsp_voice_mixer : directed + randomised scoreboard bench for the mixer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dsp_voice_mixer;

   localparam int N  = 8;
   localparam int SW = 16;
   localparam int VW = 8;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic                  mute  = 1'b0;
   logic [N*SW-1:0]       voice_sample = '0;
   logic [N*VW-1:0]       voice_vol_l  = '0;
   logic [N*VW-1:0]       voice_vol_r  = '0;
   logic signed [VW-1:0]  mvol_l = 8'sd127;
   logic signed [VW-1:0]  mvol_r = 8'sd127;
   logic [N-1:0]          eon = '0;
   logic                  busy, out_valid;
   logic signed [SW-1:0]  out_l, out_r, echo_l, echo_r;

   typedef struct {
      longint l;
      longint r;
      longint el;
      longint er;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   dsp_voice_mixer #(.N_VOICES(N), .SAMPLE_W(SW), .VOL_W(VW), .VOL_SHIFT(7)) dut (
      .clock(clock), .reset(reset), .start(start),
      .voice_sample(voice_sample), .voice_vol_l(voice_vol_l), .voice_vol_r(voice_vol_r),
      .mvol_l(mvol_l), .mvol_r(mvol_r), .eon(eon), .mute(mute),
      .busy(busy), .out_valid(out_valid),
      .out_l(out_l), .out_r(out_r), .echo_l(echo_l), .echo_r(echo_r));

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic longint fdiv128(input longint x);
      longint q;
      q = x / 128;
      if ((x % 128) != 0 && x < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint clampw(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic exp_t model();
      exp_t   e;
      longint al, ar, el, er, s, pl, pr;
      al = 0; ar = 0; el = 0; er = 0;
      for (int i = 0; i < N; i++) begin
         s  = longint'($signed(voice_sample[i*SW +: SW]));
         pl = fdiv128(s * longint'($signed(voice_vol_l[i*VW +: VW])));
         pr = fdiv128(s * longint'($signed(voice_vol_r[i*VW +: VW])));
         al = clampw(al + pl);
         ar = clampw(ar + pr);
         if (eon[i]) begin
            el = clampw(el + pl);
            er = clampw(er + pr);
         end
      end
      e.l  = mute ? 0 : clampw(fdiv128(al * longint'(mvol_l)));
      e.r  = mute ? 0 : clampw(fdiv128(ar * longint'(mvol_r)));
      e.el = el;
      e.er = er;
      return e;
   endfunction

   task automatic clear_inputs();
      voice_sample = '0;
      voice_vol_l  = '0;
      voice_vol_r  = '0;
      eon          = '0;
      mute         = 1'b0;
      mvol_l       = 8'sd127;
      mvol_r       = 8'sd127;
   endtask

   task automatic set_voice(input int i, input longint s, input longint vl, input longint vr);
      voice_sample[i*SW +: SW] = 16'(s);
      voice_vol_l[i*VW +: VW]  = 8'(vl);
      voice_vol_r[i*VW +: VW]  = 8'(vr);
   endtask

   // Pulses start, optionally re-pulses it restart_at cycles in, and watches 30 cycles.
   task automatic run_mix(input string tag, input exp_t e, input int restart_at);
      exp_t got;
      int   n, nvalid, lat;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      n = 0; nvalid = 0; lat = 0;
      while (n < 30) begin
         @(posedge clock);
         #1;
         n++;
         start = (n == restart_at);
         if (n == 1)  chk({tag, "_busy_early"}, longint'(busy), 1);
         if (n == 11) chk({tag, "_busy_after"}, longint'(busy), 0);
         if (out_valid) begin
            nvalid++;
            if (nvalid == 1 && sb.size() > 0) begin
               lat = n;
               got = sb.pop_front();
               chk({tag, "_out_l"},  longint'(out_l),  got.l);
               chk({tag, "_out_r"},  longint'(out_r),  got.r);
               chk({tag, "_echo_l"}, longint'(echo_l), got.el);
               chk({tag, "_echo_r"}, longint'(echo_r), got.er);
            end
         end
         if (n == 20) chk({tag, "_hold_l"}, longint'(out_l), e.l);
      end
      start = 1'b0;
      chk({tag, "_latency"}, longint'(lat), 10);
      chk({tag, "_nvalid"}, longint'(nvalid), 1);
      sb.delete();
   endtask

   initial begin
      exp_t e;
      int   nv;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy",   longint'(busy), 0);
      chk("rst_valid",  longint'(out_valid), 0);
      chk("rst_out_l",  longint'(out_l), 0);
      chk("rst_out_r",  longint'(out_r), 0);
      chk("rst_echo_l", longint'(echo_l), 0);
      chk("rst_echo_r", longint'(echo_r), 0);
      reset = 1'b0;

      clear_inputs();
      set_voice(0, 1000, 127, 0);
      e = '{l: 984, r: 0, el: 0, er: 0};
      run_mix("single", e, -1);

      clear_inputs();
      for (int i = 0; i < N; i++) set_voice(i, 32767, 127, 127);
      eon = 8'hFF;
      e = '{l: 32511, r: 32511, el: 32767, er: 32767};
      run_mix("saturate", e, -1);

      clear_inputs();
      set_voice(0, -32768, -128, -128);
      set_voice(1, -1, 1, 0);
      e = '{l: 32510, r: 32511, el: 0, er: 0};
      run_mix("negcorner", e, -1);

      clear_inputs();
      for (int i = 0; i < N; i++) set_voice(i, -32768, 127, 0);
      mvol_l = -8'sd128;
      mvol_r = -8'sd128;
      e = '{l: 32767, r: 0, el: 0, er: 0};
      run_mix("mastercorner", e, -1);

      clear_inputs();
      eon = 8'b0000_0010;
      set_voice(0, 4000, 64, 0);
      set_voice(1, 2000, 64, 0);
      e = '{l: 2976, r: 0, el: 1000, er: 0};
      run_mix("echogate", e, -1);

      clear_inputs();
      set_voice(0, 1000, 127, 0);
      mute = 1'b1;
      e = '{l: 0, r: 0, el: 0, er: 0};
      run_mix("mute", e, -1);
      eon = 8'b0000_0001;
      e = '{l: 0, r: 0, el: 992, er: 0};
      run_mix("mute_eon", e, -1);

      clear_inputs();
      set_voice(0, 1000, 127, 0);
      e = '{l: 984, r: 0, el: 0, er: 0};
      run_mix("restart", e, 3);

      // Abort a mix with reset while voices are still being accumulated.
      clear_inputs();
      eon = 8'b0000_0010;
      set_voice(0, 4000, 64, 0);
      set_voice(1, 2000, 64, 0);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #1;
         if (out_valid) nv++;
      end
      chk("abort_nvalid", longint'(nv), 0);
      chk("abort_busy",   longint'(busy), 0);
      chk("abort_out_l",  longint'(out_l), 0);
      chk("abort_echo_l", longint'(echo_l), 0);
      e = '{l: 2976, r: 0, el: 1000, er: 0};
      run_mix("after_abort", e, -1);

      for (int t = 0; t < 4; t++) begin
         clear_inputs();
         for (int i = 0; i < N; i++)
            set_voice(i, longint'($urandom_range(0, 65535)) - 32768,
                      longint'($urandom_range(0, 255)) - 128,
                      longint'($urandom_range(0, 255)) - 128);
         eon    = N'($urandom_range(0, 255));
         mute   = (t == 2);
         mvol_l = 8'($urandom_range(0, 255));
         mvol_r = 8'($urandom_range(0, 255));
         e = model();
         run_mix("random", e, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dsp_voice_mixer.md
Name: dsp_voice_mixer

Overview:
Time-multiplexed, parametrised voice mixer for the S-DSP audio path. It replaces the flat combinational 8-voice sum with a sequential saturating multiply-accumulate: one voice per clock, clamped after every add. It also produces an echo-send mix gated by EON and applies master volume and mute. It sits between the voice decoders and the DAC/echo stage and is started once per sample period by the major-step scheduler.

Parameters:
N_VOICES, 8, number of voices mixed per sample (1..16)
SAMPLE_W, 16, signed width of voice samples and of all outputs
VOL_W, 8, signed width of per-voice and master volumes
VOL_SHIFT, 7, arithmetic right shift applied after every volume multiply

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse that begins a mix; ignored unless idle
voice_sample  in  N_VOICES*SAMPLE_W  signed decoder outputs; voice i at [i*SAMPLE_W +: SAMPLE_W]
voice_vol_l  in  N_VOICES*VOL_W  signed left volume per voice, same packing
voice_vol_r  in  N_VOICES*VOL_W  signed right volume per voice
mvol_l  in  VOL_W  signed master volume, left
mvol_r  in  VOL_W  signed master volume, right
eon  in  N_VOICES  echo-enable per voice
mute  in  1  forces main outputs to zero; echo send unaffected
busy  out  1  high from the cycle after start until out_valid, inclusive
out_valid  out  1  one-cycle pulse; all outputs updated on this cycle
out_l, out_r  out  SAMPLE_W  signed main mix after master volume
echo_l, echo_r  out  SAMPLE_W  signed echo-send mix, no master volume applied

Behaviour:
- Reset: FSM goes to IDLE. busy=0, out_valid=0, all four outputs=0, voice index=0, accumulators=0. Reset mid-mix aborts the mix and no out_valid is produced.
- FSM states:
  - IDLE: start=1 clears the four accumulators and sets index=0 -> ACCUM.
  - ACCUM: stays for N_VOICES cycles, processing voice index 0..N_VOICES-1 in order -> MASTER.
  - MASTER: one cycle -> DONE.
  - DONE: one cycle; out_valid=1 -> IDLE.
- Latency: start sampled at edge k; out_valid is high in the cycle after edge k+N_VOICES+2. That is 10 cycles for N_VOICES=8, which fits inside the 64-step period.
- Inputs are read live, with no latching. voice i inputs are read in its ACCUM cycle; mvol and mute are read in the MASTER cycle. The caller holds them stable while busy.
- Per-voice term: p = (sample * vol) >>> VOL_SHIFT, full-precision signed product, arithmetic (floor) shift.
  - acc_l += p_l and acc_r += p_r, each computed at SAMPLE_W+2 bits, then clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - If eon[i]=1, echo accumulators receive the same p_l / p_r with the same clamp; otherwise they are unchanged.
- MASTER: m = clamp((acc * mvol) >>> VOL_SHIFT) per side. If mute=1, out_l and out_r are registered as 0.
- Outputs are registered and hold their value until the next DONE or reset.
- start asserted in any state other than IDLE is ignored (no restart, no queueing). start in the DONE cycle is also ignored.
- Corner case: -2^(SAMPLE_W-1) * -2^(VOL_W-1) >>> 7 exceeds range and must clamp to max positive.

Decomposition:
- Package dsp_pkg holds:
  - the FSM state enum (IDLE, ACCUM, MASTER, DONE);
  - the sat_clamp function, parametrised on width;
  - SAMPLE_W/VOL_W defaults;
  - the voice-count localparam, shared with the top-level DSP.
- Sub-module dsp_sat_mac: combinational multiply, shift, add, clamp. Instantiated four times (L, R, EL, ER) plus the shared multiply-clamp for the master stage.

Test Plan:
- Single voice, N=8: voice0 sample=1000, vol_l=127, others vol=0, mvol_l=127, start -> out_valid exactly 10 cycles later, out_l=984 (intermediate acc 992).
- Saturation: all 8 voices sample=32767, vol=127, mvol=127 -> acc clamps at 32767; out_l=out_r=32511.
- Negative corner and floor:
  - voice0 sample=-32768, vol=-128 -> term clamps, acc=32767.
  - voice1 sample=-1, vol=1 -> term=-1 (floor), confirming arithmetic shift.
- Echo gating: eon=8'b0000_0010, voice1 sample=2000 vol_l=64, voice0 sample=4000 vol_l=64 -> echo_l=1000; out_l (mvol 127) from acc 3000 = 2976.
- Mute: same as scenario 1 with mute=1 -> out_l=out_r=0, echo_l=echo_r=0 (eon=0); echo_l=992 when eon=1.
- Control: start pulsed again 3 cycles into a mix -> ignored, one out_valid only. Reset asserted during ACCUM -> no out_valid, outputs=0; next start completes normally.
